// File: rtl/bus_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_uart_pkg
//  Purpose  : Shared definitions for the memory-mapped UART transmitter:
//             register offsets, STATUS bit positions and the TX FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package bus_uart_pkg;

    // Word offsets decoded from bus_addr[1:0]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    // STATUS register bit positions
    localparam int ST_FULL      = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with show-ahead read data.
//  Ports    : clock, reset     - clock and synchronous active-high reset
//             push, push_data  - write request (ignored when full)
//             pop, pop_data    - read request (ignored when empty); pop_data
//                                always presents the oldest entry
//             full, empty      - occupancy flags
//             count            - number of stored entries (0..DEPTH)
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Fullness is judged on the pre-edge count, so a same-edge pop never
    // makes room for a push.
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign full     = (r_count == c_full_count);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible via the pointers.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bus_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : bus_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter on the CPU data bus.
//             Bytes written to DATA are queued in a TX FIFO and serialised
//             LSB first on uart_tx; STATUS and DIVISOR let firmware poll
//             and set the bit rate (bit period = divisor + 1 clocks).
//  Ports    : clock, reset       - clock, synchronous active-high reset
//             bus_addr           - word address, bits [1:0] decoded
//             bus_data_r         - read data, registered one edge after addr
//             bus_data_w         - write data
//             bus_mask_w         - byte-lane write enables
//             bus_write          - write strobe
//             bus_select         - decoder select, qualifies writes only
//             uart_tx            - serial output, idle high
//             irq                - high when FIFO empty and FSM idle
//  Revision : 1.0  initial release
// ============================================================================
module bus_uart_tx #(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DIV_RESET = 16'd867
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    output logic [31:0] bus_data_r,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    input  logic        bus_write,
    input  logic        bus_select,
    output logic        uart_tx,
    output logic        irq
);

    import bus_uart_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0]    w_addr;
    logic          w_wr_en;
    logic          w_data_wr;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_div_wr;
    logic          w_unused;

    logic [15:0]   r_divisor;
    logic          r_overflow;

    logic [7:0]    w_fifo_data;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          w_busy;
    logic [31:0]   w_status;

    assign w_addr    = bus_addr[1:0];
    assign w_wr_en   = bus_write & bus_select;
    assign w_data_wr = w_wr_en & (w_addr == REG_DATA) & bus_mask_w[0];
    assign w_push    = w_data_wr & ~w_full;
    assign w_ovf_set = w_data_wr & w_full;
    assign w_ovf_clr = w_wr_en & (w_addr == REG_STATUS) & bus_mask_w[0]
                     & bus_data_w[ST_OVF];
    assign w_div_wr  = w_wr_en & (w_addr == REG_DIVISOR);

    // Bus bits with no decoded meaning.
    assign w_unused  = ^{bus_addr[31:2], bus_data_w[31:16], bus_mask_w[3:2]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_divisor  <= DIV_RESET;
            r_overflow <= 1'b0;
        end else begin
            if (w_div_wr & bus_mask_w[0]) r_divisor[7:0]  <= bus_data_w[7:0];
            if (w_div_wr & bus_mask_w[1]) r_divisor[15:8] <= bus_data_w[15:8];
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (bus_data_w[7:0]),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    uart_state_t r_state,   w_state_nx;
    logic [7:0]  r_shift,   w_shift_nx;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nx;
    logic [15:0] r_timer,   w_timer_nx;
    logic        r_tx,      w_tx_nx;
    logic        w_bit_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_timer   <= w_timer_nx;
            r_tx      <= w_tx_nx;
        end
    end

    // The timer counts down from the divisor sampled at the start of each
    // bit, so a divisor write mid-bit only changes the following bits.
    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_bit_cnt_nx = r_bit_cnt;
        w_timer_nx   = r_timer;
        w_tx_nx      = r_tx;
        w_pop        = 1'b0;
        w_bit_end    = (r_timer == 16'd0);

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = START;
                    w_shift_nx = w_fifo_data;
                    w_timer_nx = r_divisor;
                    w_tx_nx    = 1'b0;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_state_nx   = DATA;
                    w_tx_nx      = r_shift[0];
                    w_shift_nx   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nx = 3'd0;
                    w_timer_nx   = r_divisor;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_timer_nx = r_divisor;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_tx_nx      = r_shift[0];
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    // Back-to-back frames: go straight to the next start bit.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_state_nx = START;
                        w_shift_nx = w_fifo_data;
                        w_timer_nx = r_divisor;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    assign w_busy  = (r_state != IDLE) | ~w_empty;
    assign irq     = ~w_busy;
    assign uart_tx = r_tx;

    // ------------------------------------------------------------------
    // Registered read port: reflects register state before this edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_status                      = '0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_BUSY]             = w_busy;
        w_status[ST_OVF]              = r_overflow;
        w_status[ST_COUNT_LSB +: CW]  = w_count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_data_r <= '0;
        end else begin
            case (w_addr)
                REG_STATUS:  bus_data_r <= w_status;
                REG_DIVISOR: bus_data_r <= {16'd0, r_divisor};
                default:     bus_data_r <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_uart_tx
//  Purpose  : Self-checking bench for bus_uart_tx. Bytes written to DATA are
//             queued as expected frames and compared by a serial monitor;
//             directed sequences check exact line timing and STATUS.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_uart_tx;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_data_r;
    logic [31:0] bus_data_w = '0;
    logic [3:0]  bus_mask_w = '0;
    logic        bus_write  = 1'b0;
    logic        bus_select = 1'b0;
    logic        uart_tx;
    logic        irq;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q [$];
    bit          mon_en = 1'b0;
    int          tb_div = 0;

    bus_uart_tx #(
        .DEPTH     (DEPTH),
        .DIV_RESET (16'd867)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_data_r (bus_data_r),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w),
        .bus_write  (bus_write),
        .bus_select (bus_select),
        .uart_tx    (uart_tx),
        .irq        (irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drives a write before the next rising edge; returns that edge's index.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic sel, output int e);
        @(negedge clock);
        bus_addr   = {30'd0, a};
        bus_data_w = d;
        bus_mask_w = m;
        bus_write  = 1'b1;
        bus_select = sel;
        @(posedge clock);
        #1;
        e = cyc;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clock);
        bus_addr   = {30'd0, a};
        bus_write  = 1'b0;
        bus_select = 1'b1;
        @(posedge clock);
        #1;
        d = bus_data_r;
    endtask

    // Expected line level after edge N+j for a frame whose start bit began
    // after edge N+1; the first n_early bits last d_early clocks, the rest d_late.
    function automatic logic exp_level(input logic [7:0] b, input int j,
                                       input int d_early, input int d_late,
                                       input int n_early);
        int t;
        int d;
        t = j - 1;
        for (int k = 0; k < 10; k++) begin
            d = (k < n_early) ? d_early : d_late;
            if (t < d) begin
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
            t -= d;
        end
        return 1'b1;
    endfunction

    // Serial monitor: samples each bit mid-period and scores the byte.
    initial begin : monitor
        int         p;
        logic [7:0] rx;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (mon_en && uart_tx === 1'b0) begin
                p = tb_div + 1;
                repeat (p / 2) @(negedge clock);
                chk("mon_start_bit", {31'd0, uart_tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge clock);
                    rx[i] = uart_tx;
                end
                repeat (p) @(negedge clock);
                chk("mon_stop_bit", {31'd0, uart_tx}, 32'd1);
                repeat (p - 1 - p / 2) @(negedge clock);
                chk("mon_frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("mon_byte", {24'd0, rx}, {24'd0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0]   rd;
        int            e_n;
        int            dmy;
        int            lows;
        logic [CW-1:0] cnt;
        int            seq [$];
        logic [7:0]    b3;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        chk("rst_bus_data_r", bus_data_r, 32'd0);
        reset = 1'b0;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd1);
        bus_rd(2'd0, rd); chk("rst_rd_data", rd, 32'h0);
        bus_rd(2'd1, rd); chk("rst_rd_status", rd, 32'h0);
        bus_rd(2'd2, rd); chk("rst_rd_divisor", rd, 32'h363);
        bus_rd(2'd3, rd); chk("rst_rd_reg3", rd, 32'h0);

        // ---------------- register access ----------------
        bus_wr(2'd2, 32'hFFFF_AB00, 4'b0010, 1'b1, dmy);
        chk("div_same_edge_read", bus_data_r, 32'h363);
        bus_rd(2'd2, rd); chk("div_mask_hi", rd, 32'hAB63);
        bus_wr(2'd2, 32'hFFFF_FF12, 4'b0001, 1'b1, dmy);
        bus_rd(2'd2, rd); chk("div_mask_lo", rd, 32'hAB12);
        bus_wr(2'd0, 32'h5A, 4'b0000, 1'b1, dmy);
        bus_wr(2'd0, 32'h5B, 4'b0001, 1'b0, dmy);
        bus_wr(2'd3, 32'hFFFF_FFFF, 4'b1111, 1'b1, dmy);
        bus_rd(2'd3, rd); chk("reg3_write_ignored", rd, 32'h0);
        bus_rd(2'd1, rd); chk("no_push_unqualified", rd, 32'h0);
        chk("idle_irq", {31'd0, irq}, 32'd1);

        // ---------------- single frame, divisor 3 ----------------
        bus_wr(2'd2, 32'd3, 4'b0011, 1'b1, dmy);
        tb_div = 3;
        mon_en = 1'b1;
        exp_q.push_back(8'h55);
        bus_wr(2'd0, 32'h55, 4'b0001, 1'b1, e_n);
        for (int j = 0; j <= 41; j++) begin
            @(negedge clock);
            if (j == 0) begin
                bus_write = 1'b0;
                chk("t2_tx_before_start", {31'd0, uart_tx}, 32'd1);
            end else if (j <= 40) begin
                chk($sformatf("t2_tx_j%0d", j), {31'd0, uart_tx},
                    {31'd0, exp_level(8'h55, j, 4, 4, 10)});
            end
            if (j == 40) chk("t2_irq_in_stop", {31'd0, irq}, 32'd0);
            if (j == 41) chk("t2_irq_drained", {31'd0, irq}, 32'd1);
        end
        repeat (4) @(negedge clock);

        // ---------------- back-to-back, divisor 0 ----------------
        bus_wr(2'd2, 32'd0, 4'b0011, 1'b1, dmy);
        tb_div = 0;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        bus_wr(2'd0, 32'h01, 4'b0001, 1'b1, e_n);
        bus_wr(2'd0, 32'h02, 4'b0001, 1'b1, dmy);
        bus_wr(2'd0, 32'h03, 4'b0001, 1'b1, dmy);
        @(negedge clock);
        bus_write = 1'b0;
        bus_addr  = 32'd1;
        chk("t3_tx_j2", {31'd0, uart_tx}, {31'd0, exp_level(8'h01, 2, 1, 1, 10)});
        for (int j = 3; j <= 34; j++) begin
            @(negedge clock);
            b3 = 8'((j - 1) / 10 + 1);
            chk($sformatf("t3_tx_j%0d", j), {31'd0, uart_tx},
                (j <= 30) ? {31'd0, exp_level(b3, (j - 1) % 10 + 1, 1, 1, 10)} : 32'd1);
            cnt = bus_data_r[16 +: CW];
            if (seq.size() == 0 || seq[$] != int'(cnt)) seq.push_back(int'(cnt));
        end
        chk("t3_count_steps", seq.size(), 32'd3);
        for (int k = 0; k < seq.size() && k < 3; k++)
            chk($sformatf("t3_count_step%0d", k), seq[k], 32'(2 - k));
        mon_en = 1'b0;
        chk("t3_scoreboard_drained", exp_q.size(), 32'd0);

        // ---------------- FIFO full / overflow, divisor 1000 ----------------
        bus_wr(2'd2, 32'd1000, 4'b0011, 1'b1, dmy);
        bus_wr(2'd0, 32'h10, 4'b0001, 1'b1, e_n);
        for (int i = 1; i <= 16; i++)
            bus_wr(2'd0, 32'h10 + 32'(i), 4'b0001, 1'b1, dmy);
        bus_rd(2'd1, rd); chk("t4_full_16", rd, 32'h0010_0003);
        bus_wr(2'd0, 32'hEE, 4'b0001, 1'b1, dmy);
        bus_rd(2'd1, rd); chk("t4_overflow_set", rd, 32'h0010_0007);
        bus_wr(2'd1, 32'h4, 4'b0001, 1'b1, dmy);
        bus_rd(2'd1, rd); chk("t4_overflow_clear", rd, 32'h0010_0003);
        // Write lands on the edge that ends the first frame and pops.
        while (cyc < e_n + 10009) @(negedge clock);
        bus_wr(2'd0, 32'hEF, 4'b0001, 1'b1, dmy);
        chk("t4_next_start", {31'd0, uart_tx}, 32'd0);
        bus_rd(2'd1, rd); chk("t4_pop_no_room", rd, 32'h000F_0006);

        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        bus_rd(2'd1, rd); chk("t4_reset_status", rd, 32'h0);
        bus_rd(2'd2, rd); chk("t4_reset_divisor", rd, 32'h363);

        // ---------------- mid-frame divisor change 3 -> 7 ----------------
        bus_wr(2'd2, 32'd3, 4'b0011, 1'b1, dmy);
        bus_wr(2'd0, 32'hA5, 4'b0001, 1'b1, e_n);
        for (int j = 0; j <= 65; j++) begin
            @(negedge clock);
            if (j == 0) bus_write = 1'b0;
            if (j == 13) begin
                bus_addr   = 32'd2;
                bus_data_w = 32'd7;
                bus_mask_w = 4'b0011;
                bus_write  = 1'b1;
            end
            if (j == 14) bus_write = 1'b0;
            if (j >= 1 && j <= 64)
                chk($sformatf("t5_tx_j%0d", j), {31'd0, uart_tx},
                    {31'd0, exp_level(8'hA5, j, 4, 8, 4)});
            if (j == 64) chk("t5_irq_in_stop", {31'd0, irq}, 32'd0);
            if (j == 65) chk("t5_irq_drained", {31'd0, irq}, 32'd1);
        end

        // ---------------- reset mid-frame ----------------
        bus_wr(2'd2, 32'd3, 4'b0011, 1'b1, dmy);
        for (int i = 0; i < 6; i++)
            bus_wr(2'd0, 32'hC0 + 32'(i), 4'b0001, 1'b1, dmy);
        for (int j = 6; j <= 21; j++) begin
            @(negedge clock);
            if (j == 6) bus_write = 1'b0;
            if (j == 10) bus_addr = 32'd1;
        end
        chk("t6_tx_bit4", {31'd0, uart_tx}, {31'd0, exp_level(8'hC0, 21, 4, 4, 10)});
        chk("t6_count_before", {27'd0, bus_data_r[16 +: CW]}, 32'd5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_tx_after_reset", {31'd0, uart_tx}, 32'd1);
        chk("t6_irq_after_reset", {31'd0, irq}, 32'd1);
        bus_rd(2'd1, rd); chk("t6_status_after_reset", rd, 32'h0);
        lows = 0;
        repeat (200) begin
            @(negedge clock);
            if (uart_tx !== 1'b1 || irq !== 1'b1) lows++;
        end
        chk("t6_no_further_frames", lows, 32'd0);

        chk("sb_empty_end", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
